// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Owns the PC, issues word requests to program memory and buffers the
// returned instructions in an in-order queue that feeds decode.
// Taken redirects from execute flush wrong-path work and restart fetch.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When defined, a redirect to a non-word-aligned target leaves the PC
//   alone, raises misalign_o and halts fetch until an aligned redirect.
//   When undefined, the low two bits of the redirect target are ignored.
//
// Handshake rules (both interfaces):
//   imem: a request transfers on a cycle where imem_req_o && imem_gnt_i.
//         imem_req_o is held with a stable imem_addr_o until granted
//         (it only drops on a redirect, which replaces the address).
//         Responses return in request order, one per imem_rvalid_i.
//   decode: an instruction transfers on a cycle where
//         instr_valid_o && instr_ready_i; instr_o/instr_pc_o are stable
//         while valid is high and ready is low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_discard;

  // PCs of outstanding memory requests, oldest at r_ipc_rd
  logic [31:0]      r_ipc [DEPTH];
  logic [PTR_W-1:0] r_ipc_wr;
  logic [PTR_W-1:0] r_ipc_rd;

  // Instruction queue towards decode
  logic [31:0]      r_q_instr [DEPTH];
  logic [31:0]      r_q_pc    [DEPTH];
  logic [PTR_W-1:0] r_q_wr;
  logic [PTR_W-1:0] r_q_rd;
  logic [CNT_W-1:0] r_count;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic             w_halt;
  logic             w_pop;
  logic [SUM_W-1:0] w_occupied;
  logic             w_room;
  logic             w_req;
  logic             w_issue;
  logic             w_drop;
  logic             w_push;
  logic [CNT_W-1:0] w_inflight_nxt;
  logic [31:0]      w_resp_pc;
  logic [31:0]      w_redirect_pc;

`ifdef MISALIGN_TRAP_EN
  logic             r_misalign;
  logic             w_target_misaligned;

  assign w_target_misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign w_halt              = r_misalign;
  assign misalign_o          = r_misalign;
  assign w_redirect_pc       = redirect_pc_i;
`else
  assign w_halt              = 1'b0;
  assign w_redirect_pc       = redirect_pc_i & 32'hFFFF_FFFC;
`endif

  assign instr_valid_o = (r_count != '0);
  assign w_pop         = instr_valid_o && instr_ready_i;

  // A slot is reserved for every outstanding request and every queued
  // instruction. The entry decode takes this cycle frees its slot early,
  // which is what lets a single-cycle memory sustain one instruction per
  // cycle without ever overfilling the queue.
  assign w_occupied = SUM_W'(r_inflight) + SUM_W'(r_count) - SUM_W'(w_pop);
  assign w_room     = (w_occupied < SUM_W'(DEPTH));

  // Requests are gated off during reset and in a redirect cycle
  assign w_req   = rst_n && !redirect_i && !w_halt && w_room;
  assign w_issue = w_req && imem_gnt_i;

  // Responses owed to a flushed path are dropped; so is any response that
  // lands in the redirect cycle itself
  assign w_drop = imem_rvalid_i && (r_discard != '0);
  assign w_push = imem_rvalid_i && (r_discard == '0) && !redirect_i;

  assign w_inflight_nxt = r_inflight + CNT_W'(w_issue) - CNT_W'(imem_rvalid_i);
  assign w_resp_pc      = r_ipc[r_ipc_rd];

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;

  // Registered queue head; outputs are forced to zero when empty
  assign instr_o    = instr_valid_o ? r_q_instr[r_q_rd] : 32'h0;
  assign instr_pc_o = instr_valid_o ? r_q_pc[r_q_rd]    : 32'h0;

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Program counter: redirect wins, otherwise advance on each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
`ifdef MISALIGN_TRAP_EN
      if (!w_target_misaligned) begin
        r_pc <= w_redirect_pc;
      end
`else
      r_pc <= w_redirect_pc;
`endif
    end else if (w_issue) begin
      r_pc <= r_pc + 32'd4;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Misalign trap flag: set by a misaligned redirect, cleared by an aligned one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (redirect_i) begin
      r_misalign <= w_target_misaligned;
    end
  end
`endif

  // Outstanding-request and discard counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (redirect_i) begin
        // Everything still outstanding after this cycle is wrong-path
        r_discard <= w_inflight_nxt;
      end else if (w_drop) begin
        r_discard <= r_discard - CNT_W'(1);
      end
    end
  end

  // In-flight PC FIFO: write on grant, read on every response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ipc_wr <= '0;
      r_ipc_rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ipc[i] <= 32'h0;
      end
    end else begin
      if (w_issue) begin
        r_ipc[r_ipc_wr] <= r_pc;
        r_ipc_wr        <= r_ipc_wr + PTR_W'(1);
      end
      if (imem_rvalid_i) begin
        r_ipc_rd <= r_ipc_rd + PTR_W'(1);
      end
    end
  end

  // Instruction queue: push kept responses, pop on decode handshake, flush on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= 32'h0;
        r_q_pc[i]    <= 32'h0;
      end
    end else if (redirect_i) begin
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_instr[r_q_wr] <= imem_rdata_i;
        r_q_pc[r_q_wr]    <= w_resp_pc;
        r_q_wr            <= r_q_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_q_rd <= r_q_rd + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // ---------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));

  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid_i && (r_inflight == '0)));

  a_inflight_cap: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_issue && (r_inflight == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a 1-cycle-latency
// memory model that can hold its responses back on demand.
// Builds with or without MISALIGN_TRAP_EN.
module tb_fetch_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic        gnt_en, ready_en, redir_en, hold_en;
  logic [31:0] redir_pc;
  logic        s_req, s_mis;
  logic [31:0] s_addr;

  logic [31:0] resp_q[$];     // granted addresses awaiting response
  logic [31:0] iss_q[$];      // every granted address, in order
  logic [31:0] got_pc_q[$];   // delivered instr_pc_o
  logic [31:0] got_ins_q[$];  // delivered instr_o
  int          got_cyc_q[$];  // cycle of each delivery
  logic [31:0] exp_q[$];      // expected delivered PCs

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs at the falling edge, sample mid-cycle.
  task automatic tick();
    @(negedge clk);
    imem_gnt_i    = gnt_en;
    instr_ready_i = ready_en;
    redirect_i    = redir_en;
    redirect_pc_i = redir_pc;
    if (!hold_en && resp_q.size() != 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(resp_q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
    #1;
    s_req  = imem_req_o;
    s_addr = imem_addr_o;
`ifdef MISALIGN_TRAP_EN
    s_mis  = misalign_o;
`else
    s_mis  = 1'b0;
`endif
    if (imem_req_o && imem_gnt_i) begin
      resp_q.push_back(imem_addr_o);
      iss_q.push_back(imem_addr_o);
    end
    if (instr_valid_o && instr_ready_i) begin
      got_pc_q.push_back(instr_pc_o);
      got_ins_q.push_back(instr_o);
      got_cyc_q.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt_i = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; redirect_pc_i = 32'h0;
    gnt_en = 1'b0; ready_en = 1'b0; redir_en = 1'b0; hold_en = 1'b0;
    redir_pc = 32'h0;
    resp_q.delete(); iss_q.delete(); got_pc_q.delete();
    got_ins_q.delete(); got_cyc_q.delete(); exp_q.delete();
    #1;
    check("rst_req",   {31'h0, imem_req_o},    32'h0);
    check("rst_addr",  imem_addr_o,            32'h0);
    check("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    check("rst_instr", instr_o,                32'h0);
    check("rst_pc",    instr_pc_o,             32'h0);
`ifdef MISALIGN_TRAP_EN
    check("rst_mis",   {31'h0, misalign_o},    32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  // Compare delivered PCs from index 'from' against exp_q
  task automatic score(input string tag, input int from);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_pc%0d", tag, i), got_pc_q[from + i], exp_q[i]);
      check($sformatf("%s_in%0d", tag, i), got_ins_q[from + i], mem_word(exp_q[i]));
    end
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base_iss;
    int base_got;

    // 1: streaming, single-cycle memory, decode always ready
    do_reset();
    gnt_en = 1'b1; ready_en = 1'b1;
    ticks(8);
    check("s_iss0", iss_q[0], 32'h0);
    check("s_iss1", iss_q[1], 32'h4);
    check("s_iss2", iss_q[2], 32'h8);
    check("s_iss3", iss_q[3], 32'hC);
    exp_q = '{32'h0, 32'h4, 32'h8};
    score("stream", 0);
    check("s_back2back01", got_cyc_q[1] - got_cyc_q[0], 32'd1);
    check("s_back2back12", got_cyc_q[2] - got_cyc_q[1], 32'd1);

    // 2: decode stalled, fetch stops after DEPTH requests, nothing lost
    do_reset();
    gnt_en = 1'b1; ready_en = 1'b0;
    ticks(10);
    check("stall_iss_cnt", iss_q.size(), 32'd2);
    check("stall_req",     {31'h0, s_req}, 32'h0);
    check("stall_valid",   {31'h0, instr_valid_o}, 32'h1);
    check("stall_headpc",  instr_pc_o, 32'h0);
    check("stall_got_cnt", got_pc_q.size(), 32'd0);
    ready_en = 1'b1;
    ticks(6);
    exp_q = '{32'h0, 32'h4, 32'h8};
    score("stall", 0);

    // 3: grant withheld, request and address held
    do_reset();
    gnt_en = 1'b0; ready_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("nogrant_req%0d", i),  {31'h0, s_req}, 32'h1);
      check($sformatf("nogrant_addr%0d", i), s_addr, 32'h0);
    end
    check("nogrant_iss", iss_q.size(), 32'd0);
    gnt_en = 1'b1;
    tick();
    gnt_en = 1'b0;
    tick();
    check("grant_iss", iss_q.size(), 32'd1);
    check("grant_addr_next", s_addr, 32'h4);

    // 4: two requests in flight, redirect drops both responses
    do_reset();
    gnt_en = 1'b1; ready_en = 1'b1; hold_en = 1'b1;
    ticks(3);
    check("redir_inflight", iss_q.size(), 32'd2);
    redir_en = 1'b1; redir_pc = 32'h40;
    tick();
    check("redir_req_low", {31'h0, s_req}, 32'h0);
    redir_en = 1'b0; hold_en = 1'b0;
    ticks(6);
    check("redir_iss2", iss_q[2], 32'h40);
    exp_q = '{32'h40, 32'h44};
    score("redir", 0);

    // 5: PC wrap from the top of the address space
    do_reset();
    gnt_en = 1'b0; ready_en = 1'b1;
    redir_en = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_en = 1'b0;
    gnt_en = 1'b1;
    tick();
    check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr_zero", s_addr, 32'h0);
    gnt_en = 1'b0;
    ticks(4);
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    score("wrap", 0);

    // 6: misaligned redirect target
    do_reset();
    gnt_en = 1'b1; ready_en = 1'b1;
    ticks(4);
    redir_en = 1'b1; redir_pc = 32'h42;
    tick();
    redir_en = 1'b0;
    base_iss = iss_q.size();
    base_got = got_pc_q.size();
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mis_flag%0d", i), {31'h0, s_mis}, 32'h1);
      check($sformatf("mis_req%0d", i),  {31'h0, s_req}, 32'h0);
    end
    check("mis_no_iss", iss_q.size(), base_iss);
    redir_en = 1'b1; redir_pc = 32'h44;
    tick();
    redir_en = 1'b0;
    base_got = got_pc_q.size();
    ticks(4);
    check("mis_clear", {31'h0, s_mis}, 32'h0);
    check("mis_resume_iss", iss_q[base_iss], 32'h44);
    exp_q = '{32'h44};
    score("mis", base_got);
`else
    ticks(5);
    check("align_iss", iss_q[base_iss], 32'h40);
    exp_q = '{32'h40, 32'h44};
    score("align", base_got);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
